// File: rtl/fifo_write_arbiter_if.sv
// Handshake bundle between the requesters/FIFO side (master) and fifo_write_arbiter (slave).
interface fifo_write_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 32
);
   localparam int ID_W = $clog2(NUM_REQ);

   logic                       flush;
   logic [0:NUM_REQ-1]         req;
   logic [0:NUM_REQ*WIDTH-1]   req_data;
   logic [0:NUM_REQ-1]         gnt;
   logic                       fifo_full;
   logic                       fifo_w_en;
   logic [0:WIDTH-1]           fifo_din;
   logic [0:ID_W-1]            fifo_src;
   logic [0:31]                stall_cnt;

   modport master (
      output flush, req, req_data, fifo_full,
      input  gnt, fifo_w_en, fifo_din, fifo_src, stall_cnt
   );

   modport slave (
      input  flush, req, req_data, fifo_full,
      output gnt, fifo_w_en, fifo_din, fifo_src, stall_cnt
   );
endinterface

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one sync_fifo write port via a one-entry output register.
// Optional back-pressure stall counter built when FIFO_ARB_STATS_EN is defined.
module fifo_write_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   fifo_write_arbiter_if.slave  bus
);
   localparam int ID_W = $clog2(NUM_REQ);

   logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
   logic               out_valid_q, out_valid_d;
   logic [0:WIDTH-1]   out_data_q, out_data_d;
   logic [ID_W-1:0]    out_src_q, out_src_d;

   logic               win_found;
   logic [ID_W-1:0]    win_id;
   logic               ready, grant, drain;
   logic [0:NUM_REQ-1] gnt_v;

   // First set request at or after rr_ptr, wrapping modulo NUM_REQ.
   always_comb begin
      int idx;
      idx       = 0;
      win_found = 1'b0;
      win_id    = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = (int'(rr_ptr_q) + k) % NUM_REQ;
         if (!win_found && bus.req[idx]) begin
            win_found = 1'b1;
            win_id    = ID_W'(idx);
         end
      end
   end

   assign ready = !out_valid_q || !bus.fifo_full;
   assign grant = ready && !bus.flush && !reset && win_found;
   assign drain = out_valid_q && !bus.fifo_full && !bus.flush && !reset;

   always_comb begin
      gnt_v = '0;
      if (grant) gnt_v[win_id] = 1'b1;
   end

   always_comb begin
      rr_ptr_d    = rr_ptr_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_src_d   = out_src_q;
      if (grant) begin
         out_valid_d = 1'b1;
         out_data_d  = bus.req_data[int'(win_id)*WIDTH +: WIDTH];
         out_src_d   = win_id;
         rr_ptr_d    = (win_id == ID_W'(NUM_REQ-1)) ? '0 : win_id + ID_W'(1);
      end else if (drain || bus.flush) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rr_ptr_q    <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_src_q   <= '0;
      end else begin
         rr_ptr_q    <= rr_ptr_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_src_q   <= out_src_d;
      end
   end

   assign bus.gnt       = gnt_v;
   assign bus.fifo_w_en = drain;
   assign bus.fifo_din  = out_data_q;
   assign bus.fifo_src  = out_src_q;

`ifdef FIFO_ARB_STATS_EN
   logic [31:0] stall_q, stall_d;

   always_comb begin
      stall_d = stall_q;
      if (out_valid_q && bus.fifo_full && !bus.flush && stall_q != 32'hFFFF_FFFF)
         stall_d = stall_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) stall_q <= '0;
      else       stall_q <= stall_d;
   end

   assign bus.stall_cnt = stall_q;
`else
   assign bus.stall_cnt = '0;
`endif
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Self-checking bench: directed vector table, reset/flush sequences, randomized run vs queue model.
module tb_fifo_write_arbiter;
   localparam int N = 4;
   localparam int W = 32;
`ifdef FIFO_ARB_STATS_EN
   localparam int ST5 = 5;
`else
   localparam int ST5 = 0;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   fifo_write_arbiter_if #(.NUM_REQ(N), .WIDTH(W)) bif();
   fifo_write_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (.clk(clk), .reset(rst), .bus(bif.slave));

   fifo_write_arbiter_if #(.NUM_REQ(3), .WIDTH(8)) bif3();
   fifo_write_arbiter #(.NUM_REQ(3), .WIDTH(8)) dut3 (.clk(clk), .reset(rst), .bus(bif3.slave));

   typedef struct { logic [0:W-1] d; int s; } ent_t;
   typedef struct { bit [N-1:0] req; bit full; bit flush; int eg; bit ewen; int esrc; bit cst; } vec_t;

   int n_chk = 0, n_fail = 0;
   ent_t sb[$];
   int m_ptr;
   longint m_stall;
   logic [0:W-1] rdata [N];
   int obs_g, obs_g3, obs_src;
   bit obs_wen;
   logic [0:31] obs_stall;
   int waitc [N];
   vec_t tbl [23];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive_data();
      for (int i = 0; i < N; i++) bif.req_data[i*W +: W] = rdata[i];
   endtask

   function automatic int pick(input logic [0:N-1] rq, input int ptr);
      for (int k = 0; k < N; k++)
         if (rq[(ptr + k) % N]) return (ptr + k) % N;
      return -1;
   endfunction

   // One clock: compare combinational/registered outputs at negedge, then advance the model.
   task automatic tick();
      int w;
      bit g, we, st;
      logic [0:N-1] eg;
      @(negedge clk);
      w  = pick(bif.req, m_ptr);
      g  = !rst && !bif.flush && (sb.size() == 0 || !bif.fifo_full) && w >= 0;
      we = sb.size() > 0 && !bif.fifo_full && !bif.flush && !rst;
      st = sb.size() > 0 && bif.fifo_full && !bif.flush && !rst;
      eg = '0;
      if (g) eg[w] = 1'b1;
      chk("gnt", 64'(bif.gnt), 64'(eg));
      chk("w_en", 64'(bif.fifo_w_en), 64'(we));
      if (we) begin
         chk("din", 64'(bif.fifo_din), 64'(sb[0].d));
         chk("src", 64'(bif.fifo_src), 64'(sb[0].s));
      end
      chk("stall_cnt", 64'(bif.stall_cnt), 64'(m_stall));
      obs_g = -1;
      for (int i = 0; i < N; i++) if (bif.gnt[i]) obs_g = (obs_g == -1) ? i : -2;
      obs_g3 = -1;
      for (int i = 0; i < 3; i++) if (bif3.gnt[i]) obs_g3 = (obs_g3 == -1) ? i : -2;
      obs_wen   = bif.fifo_w_en;
      obs_src   = int'(bif.fifo_src);
      obs_stall = bif.stall_cnt;
      if (rst) begin
         sb.delete();
         m_ptr = 0;
         m_stall = 0;
      end else begin
`ifdef FIFO_ARB_STATS_EN
         if (st && m_stall != 64'hFFFF_FFFF) m_stall++;
`endif
         if (we) void'(sb.pop_front());
         if (bif.flush) sb.delete();
         if (g) begin
            sb.push_back('{bif.req_data[w*W +: W], w});
            m_ptr = (w + 1) % N;
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      m_ptr = 0; m_stall = 0;
      rst = 1'b1;
      bif.req = '0; bif.fifo_full = 1'b0; bif.flush = 1'b0; bif.req_data = '0;
      bif3.req = 3'b111; bif3.fifo_full = 1'b0; bif3.flush = 1'b0; bif3.req_data = 24'h112233;
      rdata[0] = 32'hA000_0000; rdata[1] = 32'hDEAD_BEEF;
      rdata[2] = 32'hA000_0002; rdata[3] = 32'hA000_0003;
      drive_data();
      tick();
      tick();
      chk("reset gnt", 64'(obs_g), 64'(-1));
      chk("reset w_en", 64'(obs_wen), 64'(0));
      rst = 1'b0;

      // req, full, flush, expected grant, expected w_en, expected src, check stall
      for (int k = 0; k < 8; k++)
         tbl[k] = '{4'b1111, 1'b0, 1'b0, k % 4, k > 0, (k > 0) ? (k - 1) % 4 : -1, 1'b0};
      tbl[8]  = '{4'b0010, 1'b0, 1'b0,  1, 1'b1,  3, 1'b0};
      for (int k = 9; k < 14; k++)
         tbl[k] = '{4'b0100, 1'b1, 1'b0, -1, 1'b0, -1, 1'b0};
      tbl[14] = '{4'b0100, 1'b0, 1'b0,  2, 1'b1,  1, 1'b1};
      tbl[15] = '{4'b0010, 1'b0, 1'b0,  1, 1'b1,  2, 1'b0};
      tbl[16] = '{4'b0011, 1'b0, 1'b0,  0, 1'b1,  1, 1'b0};
      tbl[17] = '{4'b0010, 1'b0, 1'b0,  1, 1'b1,  0, 1'b0};
      tbl[18] = '{4'b0000, 1'b1, 1'b1, -1, 1'b0, -1, 1'b0};
      tbl[19] = '{4'b1011, 1'b1, 1'b0,  3, 1'b0, -1, 1'b1};
      tbl[20] = '{4'b0011, 1'b0, 1'b0,  0, 1'b1,  3, 1'b0};
      tbl[21] = '{4'b0000, 1'b0, 1'b0, -1, 1'b1,  0, 1'b0};
      tbl[22] = '{4'b0000, 1'b0, 1'b0, -1, 1'b0, -1, 1'b0};

      for (int k = 0; k < 23; k++) begin
         for (int i = 0; i < N; i++) bif.req[i] = tbl[k].req[i];
         bif.fifo_full = tbl[k].full;
         bif.flush     = tbl[k].flush;
         tick();
         chk($sformatf("tbl%0d gnt", k), 64'(obs_g), 64'(tbl[k].eg));
         chk($sformatf("tbl%0d w_en", k), 64'(obs_wen), 64'(tbl[k].ewen));
         if (tbl[k].ewen) chk($sformatf("tbl%0d src", k), 64'(obs_src), 64'(tbl[k].esrc));
         if (tbl[k].cst) chk($sformatf("tbl%0d stall", k), 64'(obs_stall), 64'(ST5));
         if (k < 4) chk($sformatf("n3 gnt%0d", k), 64'(obs_g3), 64'((k == 3) ? 0 : k));
      end

      // Reset mid-stream with requests held.
      bif.req = '1;
      bif.fifo_full = 1'b0;
      tick(); tick(); tick();
      rst = 1'b1;
      tick();
      chk("midrst gnt", 64'(obs_g), 64'(-1));
      chk("midrst w_en", 64'(obs_wen), 64'(0));
      bif.fifo_full = 1'b1;
      tick();
      chk("midrst gnt full", 64'(obs_g), 64'(-1));
      rst = 1'b0;
      bif.fifo_full = 1'b0;
      tick();
      chk("post-rst gnt", 64'(obs_g), 64'(0));
      chk("post-rst stall", 64'(obs_stall), 64'(0));

      // Randomized run; requesters hold req/data until granted.
      for (int i = 0; i < N; i++) waitc[i] = 0;
      for (int c = 0; c < 10000; c++) begin
         if (obs_g >= 0) begin
            chk("rr wait bound", 64'(waitc[obs_g] < N), 64'(1));
            waitc[obs_g] = 0;
            for (int i = 0; i < N; i++)
               if (i != obs_g && bif.req[i]) waitc[i]++;
         end
         for (int i = 0; i < N; i++) begin
            if (!bif.req[i] || i == obs_g) begin
               bif.req[i] = ($urandom_range(0, 99) < 60);
               rdata[i] = $urandom;
               if (!bif.req[i]) waitc[i] = 0;
            end
         end
         drive_data();
         bif.fifo_full = ($urandom_range(0, 99) < 30);
         bif.flush     = ($urandom_range(0, 99) < 3);
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
